// File: rtl/aes_round_ctrl.sv
// AES round sequencer: steps SubBytes/ShiftRows/MixColumns/AddRoundKey
// in order, one enable pulse per stage, advancing on each stage's done.
module aes_round_ctrl #(
    parameter int NR      = 10,
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       sub_done,
    input  logic       shift_done,
    input  logic       mix_done,
    input  logic       ark_done,
    output logic       sub_en,
    output logic       shift_en,
    output logic       mix_en,
    output logic       ark_en,
    output logic       load_sel,
    output logic [3:0] round,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE, ARK0, SUB, SHIFT, MIX, ARK, FIN
    } state_t;

    localparam logic [3:0] NR_L = 4'(NR);
    localparam logic [7:0] TO_L = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic [3:0] round_d;
    logic [7:0] wait_q, wait_d;
    logic       err_d;
    logic       first;
    logic       hit;
    logic       stage;
    logic       entry;

    // An enable is live only in a stage's first cycle; done then is stale.
    assign first = sub_en | shift_en | mix_en | ark_en;

    always_comb begin
        state_d = state_q;
        round_d = round;
        err_d   = err;
        hit     = 1'b0;
        stage   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARK0;
                    round_d = 4'd0;
                    err_d   = 1'b0;
                end
            end
            ARK0: begin
                stage = 1'b1;
                hit   = ark_done;
            end
            SUB: begin
                stage = 1'b1;
                hit   = sub_done;
            end
            SHIFT: begin
                stage = 1'b1;
                hit   = shift_done;
            end
            MIX: begin
                stage = 1'b1;
                hit   = mix_done;
            end
            ARK: begin
                stage = 1'b1;
                hit   = ark_done;
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (stage) begin
            if (abort) begin
                state_d = IDLE;
            end else if (hit && !first) begin
                unique case (state_q)
                    ARK0: begin
                        state_d = SUB;
                        round_d = 4'd1;
                    end
                    SUB:   state_d = SHIFT;
                    SHIFT: state_d = (round < NR_L) ? MIX : ARK;
                    MIX:   state_d = ARK;
                    ARK: begin
                        if (round < NR_L) begin
                            state_d = SUB;
                            round_d = round + 4'd1;
                        end else begin
                            state_d = FIN;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end else if (!first && wait_q == TO_L) begin
                state_d = IDLE;
                err_d   = 1'b1;
            end
        end

        entry  = (state_d != state_q);
        wait_d = (entry || state_q == IDLE) ? 8'd0 : wait_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wait_q   <= 8'd0;
            round    <= 4'd0;
            err      <= 1'b0;
            sub_en   <= 1'b0;
            shift_en <= 1'b0;
            mix_en   <= 1'b0;
            ark_en   <= 1'b0;
            load_sel <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            round    <= round_d;
            err      <= err_d;
            sub_en   <= entry && state_d == SUB;
            shift_en <= entry && state_d == SHIFT;
            mix_en   <= entry && state_d == MIX;
            ark_en   <= entry && (state_d == ARK0 || state_d == ARK);
            load_sel <= state_d == ARK0;
            busy     <= !(state_d == IDLE || state_d == FIN);
            done     <= state_d == FIN;
        end
    end

endmodule
